// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece codes, board geometry, palette and the
// piece plotter state encoding.
package tetris_pkg;

    localparam logic [2:0] BLK_I = 3'd0;
    localparam logic [2:0] BLK_J = 3'd1;
    localparam logic [2:0] BLK_L = 3'd2;
    localparam logic [2:0] BLK_O = 3'd3;
    localparam logic [2:0] BLK_S = 3'd4;
    localparam logic [2:0] BLK_T = 3'd5;
    localparam logic [2:0] BLK_Z = 3'd6;

    localparam int unsigned BOARD_COLS  = 10;
    localparam int unsigned BOARD_ROWS  = 20;
    localparam int unsigned CELL_PX_DEF = 4;

    // Colours are RRGGBB
    localparam logic [5:0] COL_BG = 6'b00_00_00;
    localparam logic [5:0] COL_I  = 6'b00_11_11;
    localparam logic [5:0] COL_J  = 6'b00_00_11;
    localparam logic [5:0] COL_L  = 6'b11_10_00;
    localparam logic [5:0] COL_O  = 6'b11_11_00;
    localparam logic [5:0] COL_S  = 6'b00_11_00;
    localparam logic [5:0] COL_T  = 6'b10_00_10;
    localparam logic [5:0] COL_Z  = 6'b11_00_00;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDraw,
        StDone
    } plot_state_t;

    // Extract the 2-bit offset of cell k from a packed 4-cell offset word.
    function automatic logic [1:0] cell_field(input logic [7:0] packed_v, input logic [1:0] k);
        return packed_v[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/cell_to_pixel.sv
// Maps a board cell (origin plus offset) and a pixel within that cell to
// framebuffer coordinates. Shared with the board redraw logic.
module cell_to_pixel #(
    parameter int unsigned CELL_PX  = 4,
    parameter int unsigned BOARD_X0 = 40,
    parameter int unsigned BOARD_Y0 = 0
) (
    input  logic [3:0] origin_x,
    input  logic [4:0] origin_y,
    input  logic [1:0] lx,
    input  logic [1:0] ly,
    input  logic [2:0] px,
    input  logic [2:0] py,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y
);

    // Sums are formed at 10 bits and then truncated to the framebuffer widths.
    always_comb begin
        pix_x = 8'(10'(BOARD_X0) + (10'(origin_x) + 10'(lx)) * 10'(CELL_PX) + 10'(px));
        pix_y = 7'(10'(BOARD_Y0) + (10'(origin_y) + 10'(ly)) * 10'(CELL_PX) + 10'(py));
    end

endmodule

// File: rtl/piece_plotter.sv
// Draws or erases one tetromino: latches the request, reads the piece table
// once, then emits one framebuffer plot per pixel of each of the four cells.
module piece_plotter
    import tetris_pkg::*;
#(
    parameter int unsigned CELL_PX   = CELL_PX_DEF,
    parameter int unsigned BOARD_X0  = 40,
    parameter int unsigned BOARD_Y0  = 0,
    parameter logic [5:0]  BG_COLOUR = COL_BG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       erase,
    input  logic [2:0] block,
    input  logic [1:0] rotation,
    input  logic [3:0] origin_x,
    input  logic [4:0] origin_y,
    output logic [2:0] lut_block,
    output logic [1:0] lut_rotation,
    input  logic [7:0] lut_x,
    input  logic [7:0] lut_y,
    input  logic [5:0] lut_colour,
    output logic       busy,
    output logic       done,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [5:0] vga_colour
);

    localparam logic [2:0] PX_LAST = 3'(CELL_PX - 1);

    plot_state_t state;

    logic [3:0] ox_q;
    logic [4:0] oy_q;
    logic       erase_q;
    logic [7:0] xs_q;
    logic [7:0] ys_q;
    logic [5:0] colour_q;
    logic [1:0] k_q;
    logic [2:0] px_q;
    logic [2:0] py_q;
    logic [7:0] hold_x;
    logic [6:0] hold_y;
    logic [5:0] hold_colour;

    logic [1:0] cell_lx;
    logic [1:0] cell_ly;
    logic [7:0] pix_x;
    logic [6:0] pix_y;

    always_comb begin
        cell_lx = cell_field(xs_q, k_q);
        cell_ly = cell_field(ys_q, k_q);
    end

    cell_to_pixel #(
        .CELL_PX  (CELL_PX),
        .BOARD_X0 (BOARD_X0),
        .BOARD_Y0 (BOARD_Y0)
    ) u_cell_to_pixel (
        .origin_x (ox_q),
        .origin_y (oy_q),
        .lx       (cell_lx),
        .ly       (cell_ly),
        .px       (px_q),
        .py       (py_q),
        .pix_x    (pix_x),
        .pix_y    (pix_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            lut_block    <= '0;
            lut_rotation <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            erase_q      <= 1'b0;
            xs_q         <= '0;
            ys_q         <= '0;
            colour_q     <= '0;
            k_q          <= '0;
            px_q         <= '0;
            py_q         <= '0;
            hold_x       <= '0;
            hold_y       <= '0;
            hold_colour  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        // The table address registers double as the request latch.
                        lut_block    <= block;
                        lut_rotation <= rotation;
                        ox_q         <= origin_x;
                        oy_q         <= origin_y;
                        erase_q      <= erase;
                        state        <= StLoad;
                    end
                end
                StLoad: begin
                    xs_q     <= lut_x;
                    ys_q     <= lut_y;
                    colour_q <= erase_q ? BG_COLOUR : lut_colour;
                    k_q      <= '0;
                    px_q     <= '0;
                    py_q     <= '0;
                    state    <= StDraw;
                end
                StDraw: begin
                    hold_x      <= pix_x;
                    hold_y      <= pix_y;
                    hold_colour <= colour_q;
                    if (px_q != PX_LAST) begin
                        px_q <= px_q + 3'd1;
                    end else begin
                        px_q <= '0;
                        if (py_q != PX_LAST) begin
                            py_q <= py_q + 3'd1;
                        end else begin
                            py_q <= '0;
                            if (k_q != 2'd3) begin
                                k_q <= k_q + 2'd1;
                            end else begin
                                state <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Outside DRAW the pixel outputs show the last plotted pixel.
    always_comb begin
        plot       = (state == StDraw);
        done       = (state == StDone);
        busy       = (state != StIdle);
        vga_x      = plot ? pix_x : hold_x;
        vga_y      = plot ? pix_y : hold_y;
        vga_colour = plot ? colour_q : hold_colour;
    end

endmodule

// File: tb/tb_piece_plotter.sv
// Directed and randomised bench for piece_plotter with a behavioural piece
// table and a pixel-sequence reference model.
module tb_piece_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       erase;
    logic [2:0] block;
    logic [1:0] rotation;
    logic [3:0] origin_x;
    logic [4:0] origin_y;
    logic [2:0] lut_block;
    logic [1:0] lut_rotation;
    logic [7:0] lut_x;
    logic [7:0] lut_y;
    logic [5:0] lut_colour;
    logic       busy;
    logic       done;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [5:0] vga_colour;

    int n_checks = 0;
    int n_fails  = 0;

    int ncnt = 0;
    int t0   = 0;
    int done_cnt;
    int done_cyc;
    logic [20:0] q_pix[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    piece_plotter dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .erase        (erase),
        .block        (block),
        .rotation     (rotation),
        .origin_x     (origin_x),
        .origin_y     (origin_y),
        .lut_block    (lut_block),
        .lut_rotation (lut_rotation),
        .lut_x        (lut_x),
        .lut_y        (lut_y),
        .lut_colour   (lut_colour),
        .busy         (busy),
        .done         (done),
        .plot         (plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour)
    );

    // Behavioural piece table: O and I rot 1 are the real shapes, the rest
    // are arbitrary but distinct per (block, rotation).
    function automatic logic [21:0] lut_f(input logic [2:0] b, input logic [1:0] r);
        logic [7:0] xs;
        logic [7:0] ys;
        logic [5:0] c;
        for (int k = 0; k < 4; k++) begin
            xs[2*k +: 2] = 2'((int'(b) + k + int'(r)) % 4);
            ys[2*k +: 2] = 2'((int'(b) * k + int'(r)) % 4);
        end
        c = {b, r, 1'b1};
        if (b == 3'd3) begin
            xs = {2'd0, 2'd1, 2'd0, 2'd1};
            ys = {2'd0, 2'd0, 2'd1, 2'd1};
            c  = 6'b11_11_00;
        end
        if (b == 3'd0 && r == 2'd1) begin
            xs = {2'd2, 2'd2, 2'd2, 2'd2};
            ys = {2'd0, 2'd1, 2'd2, 2'd3};
            c  = 6'b00_11_11;
        end
        return {xs, ys, c};
    endfunction

    always_comb {lut_x, lut_y, lut_colour} = lut_f(lut_block, lut_rotation);

    // Cycle n of a request is the cycle after its n-th clock edge (start edge = 0).
    always @(negedge clk) begin
        ncnt = ncnt + 1;
        if (plot) begin
            q_pix.push_back({vga_x, vga_y, vga_colour});
            q_cyc.push_back(ncnt - t0);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = ncnt - t0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] b, input logic [1:0] r, input logic [3:0] ox,
                            input logic [4:0] oy, input logic er);
        @(negedge clk);
        block    = b;
        rotation = r;
        origin_x = ox;
        origin_y = oy;
        erase    = er;
        start    = 1'b1;
        @(posedge clk);
        #1;
        t0       = ncnt;
        start    = 1'b0;
        done_cnt = 0;
        done_cyc = -1;
        q_pix.delete();
        q_cyc.delete();
    endtask

    task automatic check_piece(input string tag, input logic [2:0] b, input logic [1:0] r,
                               input logic [3:0] ox, input logic [4:0] oy, input logic er);
        logic [21:0] ent;
        logic [20:0] exp_pix[$];
        logic [7:0]  xs;
        logic [7:0]  ys;
        logic [5:0]  c;
        int x;
        int y;
        ent = lut_f(b, r);
        xs  = ent[21:14];
        ys  = ent[13:6];
        c   = er ? 6'b00_00_00 : ent[5:0];
        for (int k = 0; k < 4; k++)
            for (int py = 0; py < 4; py++)
                for (int px = 0; px < 4; px++) begin
                    x = 40 + (int'(ox) + int'(xs[2*k +: 2])) * 4 + px;
                    y = (int'(oy) + int'(ys[2*k +: 2])) * 4 + py;
                    exp_pix.push_back({8'(x), 7'(y), c});
                end
        chk({tag, " plots"}, q_pix.size(), 64);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_cyc, 66);
        if (q_pix.size() > 0) begin
            chk({tag, " first_plot_cycle"}, q_cyc[0], 2);
            chk({tag, " last_plot_cycle"}, q_cyc[q_cyc.size() - 1], 65);
        end
        for (int i = 0; i < q_pix.size() && i < 64; i++)
            chk($sformatf("%s pix%0d", tag, i), q_pix[i], exp_pix[i]);
        chk({tag, " hold_pixel"}, {vga_x, vga_y, vga_colour}, exp_pix[63]);
    endtask

    // change: drive Z rot 3 after the start edge instead of random scramble.
    task automatic run_piece(input string tag, input logic [2:0] b, input logic [1:0] r,
                             input logic [3:0] ox, input logic [4:0] oy, input logic er,
                             input bit noise, input bit change);
        do_start(b, r, ox, oy, er);
        for (int c = 1; c <= 67; c++) begin
            @(negedge clk);
            start = noise && (c == 10 || c == 66);
            if (change) begin
                block    = 3'd6;
                rotation = 2'd3;
            end else begin
                block    = 3'($urandom_range(0, 7));
                rotation = 2'($urandom_range(0, 3));
                origin_x = 4'($urandom_range(0, 9));
                origin_y = 5'($urandom_range(0, 19));
                erase    = 1'($urandom_range(0, 1));
            end
        end
        #1;
        chk({tag, " busy_idle"}, busy, 0);
        chk({tag, " done_idle"}, done, 0);
        start = 1'b0;
        check_piece(tag, b, r, ox, oy, er);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        erase    = 1'b0;
        block    = '0;
        rotation = '0;
        origin_x = '0;
        origin_y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst lut_block", lut_block, 0);
        chk("rst lut_rotation", lut_rotation, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst plot", plot, 0);
        chk("rst vga", {vga_x, vga_y, vga_colour}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_piece("o_draw", 3'd3, 2'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        if (q_pix.size() == 64) begin
            chk("o_draw first", q_pix[0], {8'd44, 7'd4, 6'b11_11_00});
            chk("o_draw plot16", q_pix[16][20:6], {8'd40, 7'd4});
            chk("o_draw last", q_pix[63][20:6], {8'd43, 7'd3});
        end
        run_piece("o_erase", 3'd3, 2'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        run_piece("i_rot1", 3'd0, 2'd1, 4'd3, 5'd5, 1'b0, 1'b0, 1'b0);
        if (q_pix.size() == 64)
            chk("i_rot1 first", q_pix[0], {8'd60, 7'd32, 6'b00_11_11});
        run_piece("restart", 3'd4, 2'd2, 4'd7, 5'd12, 1'b0, 1'b1, 1'b0);
        run_piece("latch", 3'd5, 2'd0, 4'd2, 5'd9, 1'b0, 1'b0, 1'b1);
        chk("latch lut_block", lut_block, 5);
        chk("latch lut_rotation", lut_rotation, 0);

        // Reset in the middle of a draw.
        do_start(3'd3, 2'd0, 4'd1, 5'd1, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst plot", plot, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst lut_block", lut_block, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst no_done", done_cnt, 0);
        chk("midrst plots_cut", q_pix.size() < 64, 1);
        run_piece("after_rst", 3'd1, 2'd3, 4'd9, 5'd19, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [2:0] b;
            logic [1:0] r;
            logic [3:0] ox;
            logic [4:0] oy;
            logic       er;
            b  = 3'($urandom_range(0, 7));
            r  = 2'($urandom_range(0, 3));
            ox = 4'($urandom_range(0, 9));
            oy = 5'($urandom_range(0, 19));
            er = 1'($urandom_range(0, 1));
            run_piece($sformatf("rand%0d", i), b, r, ox, oy, er, i[0], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/piece_plotter.md
Name: piece_plotter

Overview:
- Sequencer that draws or erases one tetromino on the VGA framebuffer.
- On start it latches block, rotation and board origin, and drives the piece lookup table (block/rotation in; packed X, Y, colour out).
- It then walks the 4 cells and emits one framebuffer plot per pixel of each CELL_PX x CELL_PX square.
- Sits between the game FSM (issues start/erase) and the VGA adapter (consumes plot/x/y/colour).

Parameters:
- CELL_PX, 4, pixel edge length of one board cell (power of 2, 2..8)
- BOARD_X0, 40, framebuffer x of board column 0
- BOARD_Y0, 0, framebuffer y of board row 0
- BG_COLOUR, 6'b00_00_00, colour written in erase mode

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request: draw/erase one piece; sampled only in IDLE
- erase  in  1  sampled with start; 1 = write BG_COLOUR instead of piece colour
- block  in  3  piece code 0..6 (I,J,L,O,S,T,Z)
- rotation  in  2  rotation 0..3
- origin_x  in  4  board column of piece origin, 0..9
- origin_y  in  5  board row of piece origin, 0..19
- lut_block  out  3  piece code driven to lookup table
- lut_rotation  out  2  rotation driven to lookup table
- lut_x  in  8  packed cell x offsets; cell k (k=0..3) at bits [2k+1:2k]
- lut_y  in  8  packed cell y offsets, same packing
- lut_colour  in  6  piece colour RRGGBB
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse when the piece is complete
- plot  out  1  framebuffer write strobe
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  6  pixel colour

Behaviour:
- States: IDLE, LOAD, DRAW, DONE.
- Reset (async, any state): state = IDLE. All counters and latches are 0. lut_block = 0, lut_rotation = 0. busy, done, plot = 0. vga_x, vga_y, vga_colour = 0.
- IDLE: start = 1 latches block, rotation, origin_x, origin_y and erase, then goes to LOAD. Otherwise stays in IDLE.
- LOAD (1 cycle): lut_block and lut_rotation are registered outputs from the latches. The lookup table is combinational. At the end of LOAD, lut_x, lut_y and lut_colour are captured. If erase is latched, BG_COLOUR is captured instead of lut_colour. The cell counter k, pixel column px and pixel row py are cleared.
- DRAW: plot = 1 every cycle.
  - Pixel order: px increments fastest, then py, then k.
  - Cell k offsets: lx = X[2k+1:2k], ly = Y[2k+1:2k].
  - vga_x = BOARD_X0 + (origin_x + lx)*CELL_PX + px.
  - vga_y = BOARD_Y0 + (origin_y + ly)*CELL_PX + py.
  - Compute both in 10 bits, then truncate to 8 and 7 bits. With defaults the maximum values are 91 and 91, so no truncation occurs.
  - vga_colour = captured colour.
  - After k = 3, py = px = CELL_PX-1, go to DONE.
- DONE (1 cycle): done = 1, plot = 0, then go to IDLE.
- Timing: start sampled at edge 0 → LOAD in cycle 1 → DRAW in cycles 2..(1 + 4*CELL_PX²) → DONE in the next cycle. With defaults: 64 plots in cycles 2..65, done in cycle 66, IDLE in cycle 67.
- busy = 1 in LOAD, DRAW and DONE.
- start outside IDLE (including the DONE cycle) is ignored; nothing is queued.
- Changes to block, rotation, origin or erase after the start sample have no effect on the current piece.
- Duplicate cells are not possible from the table; no dedup is performed.
- Invalid block code 7: whatever the table returns is drawn; no special case.
- plot is combinationally (state == DRAW). vga_x, vga_y and vga_colour hold their last value outside DRAW.

Decomposition:
- Shared package tetris_pkg:
  - block code constants BLK_I..BLK_Z
  - BOARD_COLS = 10, BOARD_ROWS = 20
  - CELL_PX default
  - colour constants
  - state enum for this FSM
- One natural sub-module, cell_to_pixel: combinational mapping of origin, lx/ly, px/py to vga_x/vga_y. It is reused by the board redraw block.

Test Plan:
- O piece, rot 0, origin (0,0), erase = 0, defaults → 64 plots. First plot (44,4) with colour 6'b11_11_00 (cell 0 = (1,1)). Plot 16 is (40,4). Last plot (43,3). done in cycle 66.
- Same request with erase = 1 → identical coordinate sequence, vga_colour = 6'b000000 on all 64 plots.
- I piece, rot 1, origin (3,5) → first plot (60,32), colour 6'b00_11_11. All 64 plots have x in 60..63 and y in 20..35.
- start pulsed again at cycles 10 and 66 during a draw → exactly 64 plots, one done pulse, state back to IDLE at cycle 67.
- reset asserted mid-DRAW at cycle 20 → plot, busy and done = 0 immediately. No done pulse. A new start after release runs a full 64-plot draw.
- block/rotation changed on the cycle after start (T rot 0 → Z rot 3) → pixels still follow the T rot 0 offsets. lut_block stays 5 until the next start.
